// File: rtl/udp_oe_tx_packetizer.sv
// udp_oe_tx_packetizer: per-channel UDP/IPv4/Ethernet TX framer.
// Splits a 64-bit payload stream into fixed-size packets behind a 42-byte header.
// Ports: clk, rst (sync, active high), tx_rst (channel soft reset, same effect);
//   CSR inputs fpga_/host_ mac/ip/udp_port, payload_per_packet, checksum_ip;
//   s_t* payload AXI-S slave; m_t* frame AXI-S master; pkt_count, cfg_err.
// Optional: define UDP_OE_TX_STATS_EN for tx_byte_count / tx_stall_cycles.
module udp_oe_tx_packetizer #(
  parameter int          MAX_PAYLOAD = 1472,
  parameter logic [7:0]  TTL         = 8'h40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_rst,
  input  logic [47:0] fpga_mac_adr,
  input  logic [31:0] fpga_ip_adr,
  input  logic [15:0] fpga_udp_port,
  input  logic [47:0] host_mac_adr,
  input  logic [31:0] host_ip_adr,
  input  logic [15:0] host_udp_port,
  input  logic [15:0] payload_per_packet,
  input  logic [15:0] checksum_ip,
  input  logic [63:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic [31:0] pkt_count,
  output logic        cfg_err
`ifdef UDP_OE_TX_STATS_EN
  ,
  output logic [47:0] tx_byte_count,
  output logic [31:0] tx_stall_cycles
`endif
);

  localparam logic [15:0] MAXP = 16'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_HDR, S_MIX, S_TAIL
  } state_t;

  state_t        r_state;
  logic [319:0]  r_hdr;
  logic [7:0]    r_cnt;
  logic [7:0]    r_nw;
  logic [15:0]   r_held;
  logic [63:0]   r_m_tdata;
  logic [7:0]    r_m_tkeep;
  logic          r_m_tvalid;
  logic          r_m_tlast;
  logic [31:0]   r_pkt_count;
  logic          r_cfg_err;

  logic          w_rst;
  logic          w_ld;
  logic [15:0]   w_p8;
  logic [15:0]   w_pe;
  logic          w_adj;
  logic [15:0]   w_ip_len;
  logic [15:0]   w_udp_len;
  logic [15:0]   w_ip_id;
  logic [17:0]   w_sum;
  logic [16:0]   w_f1;
  logic [15:0]   w_f2;
  logic [15:0]   w_csum;
  logic [319:0]  w_hdr;
  logic [7:0]    w_nw;

  // Header is held big-endian; each wire word needs byte 0 in [7:0].
  function automatic logic [63:0] f_bswap(input logic [63:0] d);
    for (int k = 0; k < 8; k++)
      f_bswap[8*k +: 8] = d[63-8*k -: 8];
  endfunction

  assign w_rst = rst | tx_rst;
  assign w_ld  = !r_m_tvalid | m_tready;

  assign s_tready  = (r_state == S_MIX) & w_ld;
  assign m_tdata   = r_m_tdata;
  assign m_tkeep   = r_m_tkeep;
  assign m_tvalid  = r_m_tvalid;
  assign m_tlast   = r_m_tlast;
  assign pkt_count = r_pkt_count;
  assign cfg_err   = r_cfg_err;

  assign w_p8 = {payload_per_packet[15:3], 3'b000};

  always_comb begin
    w_pe = w_p8;
    if (w_p8 < 16'd8)
      w_pe = 16'd8;
    else if (w_p8 > MAXP)
      w_pe = MAXP;
  end

  assign w_adj     = (w_pe != payload_per_packet);
  assign w_ip_len  = 16'd28 + w_pe;
  assign w_udp_len = 16'd8 + w_pe;
  assign w_ip_id   = r_pkt_count[15:0];
  assign w_nw      = w_pe[10:3];

  // End-around carry: two folds always absorb an 18-bit sum.
  assign w_sum  = {2'b00, checksum_ip} + {2'b00, w_ip_len}
                + {2'b00, w_ip_id};
  assign w_f1   = {1'b0, w_sum[15:0]} + {15'd0, w_sum[17:16]};
  assign w_f2   = w_f1[15:0] + {15'd0, w_f1[16]};
  assign w_csum = ~w_f2;

  assign w_hdr = {
    host_mac_adr, fpga_mac_adr, 16'h0800,
    16'h4500, w_ip_len, w_ip_id, 16'h4000,
    TTL, 8'h11, w_csum, fpga_ip_adr, host_ip_adr,
    fpga_udp_port, host_udp_port, w_udp_len
  };

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state     <= S_IDLE;
      r_hdr       <= '0;
      r_cnt       <= '0;
      r_nw        <= '0;
      r_held      <= '0;
      r_m_tdata   <= '0;
      r_m_tkeep   <= '0;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_pkt_count <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      if (w_ld) begin
        r_m_tvalid <= 1'b0;
        r_m_tlast  <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (s_tvalid)
            r_state <= S_CALC;
        end
        S_CALC: begin
          r_hdr   <= w_hdr;
          r_nw    <= w_nw;
          r_cnt   <= '0;
          r_held  <= '0;
          if (w_adj)
            r_cfg_err <= 1'b1;
          r_state <= S_HDR;
        end
        S_HDR: begin
          if (w_ld) begin
            r_m_tdata  <= f_bswap(r_hdr[319:256]);
            r_m_tkeep  <= 8'hFF;
            r_m_tvalid <= 1'b1;
            r_hdr      <= {r_hdr[255:0], 64'h0};
            if (r_cnt == 8'd4) begin
              r_cnt   <= '0;
              r_state <= S_MIX;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        S_MIX: begin
          // Two-byte skew: UDP csum (0) leads, then each word's top
          // two bytes spill into the next output word.
          if (w_ld && s_tvalid) begin
            r_m_tdata  <= {s_tdata[47:0], r_held};
            r_m_tkeep  <= 8'hFF;
            r_m_tvalid <= 1'b1;
            r_held     <= s_tdata[63:48];
            if (r_cnt == r_nw - 8'd1)
              r_state <= S_TAIL;
            else
              r_cnt <= r_cnt + 8'd1;
          end
        end
        S_TAIL: begin
          if (r_m_tvalid && r_m_tlast && m_tready) begin
            r_pkt_count <= r_pkt_count + 32'd1;
            r_state     <= S_IDLE;
          end else if (w_ld) begin
            r_m_tdata  <= {48'h0, r_held};
            r_m_tkeep  <= 8'h03;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef UDP_OE_TX_STATS_EN
  logic [47:0] r_byte_cnt;
  logic [31:0] r_stall_cnt;
  logic [48:0] w_bsum;

  assign w_bsum = {1'b0, r_byte_cnt}
                + 49'($countones(r_m_tkeep));

  assign tx_byte_count   = r_byte_cnt;
  assign tx_stall_cycles = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_byte_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_m_tvalid && m_tready)
        r_byte_cnt <= w_bsum[48] ? '1 : w_bsum[47:0];
      if (r_m_tvalid && !m_tready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/udp_oe_tx_packetizer.md
Name: udp_oe_tx_packetizer

Overview:
- Per-channel TX framing stage; sits directly downstream of the UDP offload engine CSR block.
- Consumes the shared CSR fields (MAC/IP/port/payload_per_packet/checksum_ip) and the channel tx_rst.
- Segments a 64-bit kernel I/O-pipe payload stream into fixed-size packets, prepending a 42-byte Ethernet/IPv4/UDP header, and emits AXI-S frames to the Ethernet MAC TX.

Parameters:
- MAX_PAYLOAD, 1472, upper clamp on payload bytes per packet (multiple of 8)
- TTL, 8'h40, IPv4 TTL field

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tx_rst  in  1  channel soft reset from CSR; identical effect to rst
- fpga_mac_adr  in  48  source MAC
- fpga_ip_adr  in  32  source IP
- fpga_udp_port  in  16  source UDP port
- host_mac_adr  in  48  destination MAC
- host_ip_adr  in  32  destination IP
- host_udp_port  in  16  destination UDP port
- payload_per_packet  in  16  payload bytes per packet (P)
- checksum_ip  in  16  host-precomputed one's-complement partial sum of constant IPv4 header words
- s_tdata  in  64  payload word; byte 0 = [7:0]
- s_tvalid  in  1  payload valid
- s_tready  out  1  payload accept
- m_tdata  out  64  frame word; [7:0] first on wire
- m_tkeep  out  8  byte enables
- m_tvalid  out  1  frame valid
- m_tlast  out  1  last word of frame
- m_tready  in  1  MAC ready
- pkt_count  out  32  frames completed (wraps)
- cfg_err  out  1  sticky: P was clamped/rounded
- tx_byte_count  out  48  frame bytes sent (UDP_OE_TX_STATS_EN only)
- tx_stall_cycles  out  32  cycles with m_tvalid & !m_tready (UDP_OE_TX_STATS_EN only)

Behaviour:
- Reset (rst|tx_rst): state IDLE, m_tvalid=0, m_tlast=0, m_tkeep=0, m_tdata=0, s_tready=0, pkt_count=0, cfg_err=0, stats=0. Mid-frame reset truncates the frame; m_tvalid=0 on the following cycle.
- P effective (Pe): P[2:0] cleared; <8 → 8; >MAX_PAYLOAD → MAX_PAYLOAD. Any adjustment sets cfg_err (cleared only by reset).
- IDLE → CALC when s_tvalid=1 (no word consumed). CALC (1 cycle):
  - Latch all CSR fields and Pe.
  - ip_len = 28+Pe; udp_len = 8+Pe; ip_id = pkt_count[15:0].
  - sum = checksum_ip + ip_len + ip_id (18 bit); fold carries twice; ip_csum = ~folded.
  - Go to HDR.
- CSR changes during a frame do not affect it.
- HDR: emit words 0–4 (40 bytes) in network byte order:
  - dst MAC=host, src MAC=fpga, ethertype 0800
  - 45 00 ip_len ip_id 4000 TTL 11 ip_csum src_ip dst_ip
  - src_port dst_port udp_len
- Then MIX: each word = {2 held bytes, 6 low bytes of s_tdata}.
  - First MIX word's held bytes = UDP checksum 0000.
  - Thereafter held bytes = s_tdata[63:48] of previous accepted word.
  - s_tready = (state==MIX) & (!m_tvalid | m_tready).
- After Pe/8 payload words → TAIL: one word, held 2 bytes in [15:0], m_tkeep=8'h03, m_tlast=1.
- Frame = 42+Pe bytes = Pe/8+6 words; all non-tail words tkeep=FF.
- Output register: new word loads only when !m_tvalid | m_tready; m_tvalid/m_tdata stable while stalled.
- On TAIL accept: pkt_count++ (wraps 2^32−1→0); → IDLE. No gap required; CALC adds one bubble per frame.
- s_tvalid low in MIX: m_tvalid drops after the current word is taken; resume seamlessly.

Optional Feature:
- UDP_OE_TX_STATS_EN defined: tx_byte_count += m_tkeep popcount per accepted word; tx_stall_cycles++ per stalled cycle; both saturate, reset to 0.
- Not defined: ports absent, no logic.

Test Plan:
- fpga 10.0.0.2:5000, host 10.0.0.1:6000, P=64, 8 input words, m_tready=1 → 14 words; word5[15:0]=0000; tail tkeep=03 carries input7[63:48]; ip_len=0x005C, udp_len=0x0048, ip_csum matches software reference; pkt_count=1.
- P=5 → Pe=8, cfg_err=1, 7-word frame. P=2000 → Pe=1472, 190 words.
- Random m_tready (50%) over 3 back-to-back P=256 frames → bit-exact frames; m_tdata stable while stalled; ip_id 0,1,2.
- checksum_ip=FFFF, ip_len+ip_id causing double carry → ip_csum equals folded reference.
- tx_rst asserted at frame word 7 → m_tvalid=0 next cycle; next frame starts cleanly with ip_id 0.
- STATS_EN, P=64, m_tready low 10 cycles during frame → tx_byte_count=106, tx_stall_cycles=10.
